// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle CPU control sequencer with memory stall timeout and retired-instruction counter
module cycle_sequencer #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               WaitRequest,
  input  logic               MemOp,
  input  logic               WbEn,
  input  logic               Halt,
  output logic [STATE_W-1:0] State,
  output logic               Active,
  output logic               Fault,
  output logic [CNT_W-1:0]   InstrCount
);
  localparam int SC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [STATE_W-1:0] {
    HALTED    = STATE_W'(0),
    FETCH     = STATE_W'(1),
    DECODE    = STATE_W'(2),
    EXEC      = STATE_W'(3),
    MEM       = STATE_W'(4),
    WRITEBACK = STATE_W'(5),
    FAULT     = STATE_W'(6)
  } state_t;
  state_t state, nxt;
  logic [SC_W-1:0] stall;
  logic wb_lat, stalling, timeout, done;
  // next state: normal sequencing, overridden by a stall timeout; done marks a retiring instruction
  always_comb begin
    stalling = (state == FETCH || state == MEM) && WaitRequest;
    timeout  = (TIMEOUT > 0) && stalling && (stall == SC_W'(TIMEOUT - 1));
    nxt = FETCH;
    case (state)
      HALTED:    nxt = HALTED;
      FETCH:     nxt = WaitRequest ? FETCH : DECODE;
      DECODE:    nxt = EXEC;
      EXEC:      nxt = Halt ? HALTED : MemOp ? MEM : WbEn ? WRITEBACK : FETCH;
      MEM:       nxt = WaitRequest ? MEM : wb_lat ? WRITEBACK : FETCH;
      WRITEBACK: nxt = FETCH;
      FAULT:     nxt = FAULT;
      default:   nxt = FETCH;
    endcase
    if (timeout) nxt = FAULT;
    done = state == WRITEBACK || (state == MEM && nxt == FETCH) ||
           (state == EXEC && (nxt == FETCH || nxt == HALTED));
  end
  // state, stall counter, WbEn captured in EXEC for the MEM exit, and retired count
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      stall      <= '0;
      wb_lat     <= 1'b0;
      InstrCount <= '0;
    end else begin
      state <= nxt;
      stall <= (nxt != state) ? '0 : stalling ? stall + 1'b1 : stall;
      if (state == EXEC) wb_lat <= WbEn;
      if (done) InstrCount <= InstrCount + 1'b1;
    end
  end
  assign State  = state;
  assign Active = !(state == HALTED || state == FAULT);
  assign Fault  = state == FAULT;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: scoreboard bench for cycle_sequencer with default and small-timeout/narrow-counter instances
module tb_cycle_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, WaitRequest = 1'b0, MemOp = 1'b0, WbEn = 1'b0, Halt = 1'b0;
  logic [2:0]  state_a, state_b;
  logic        active_a, active_b, fault_a, fault_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int          d;
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cycle_sequencer dut_a (
    .clk(clk), .reset(reset), .WaitRequest(WaitRequest), .MemOp(MemOp), .WbEn(WbEn), .Halt(Halt),
    .State(state_a), .Active(active_a), .Fault(fault_a), .InstrCount(cnt_a)
  );

  cycle_sequencer #(.STATE_W(3), .CNT_W(2), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .WaitRequest(WaitRequest), .MemOp(MemOp), .WbEn(WbEn), .Halt(Halt),
    .State(state_b), .Active(active_b), .Fault(fault_b), .InstrCount(cnt_b)
  );

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor: outputs are registered, so compare at the falling edge after each pushed step
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      logic ea, ef;
      e  = q.pop_front();
      ea = !(e.st == 3'd0 || e.st == 3'd6);
      ef = e.st == 3'd6;
      if (e.d == 0) begin
        chk("a.State", {13'd0, state_a}, {13'd0, e.st});
        chk("a.Active", {15'd0, active_a}, {15'd0, ea});
        chk("a.Fault", {15'd0, fault_a}, {15'd0, ef});
        chk("a.InstrCount", cnt_a, e.cnt);
      end else begin
        chk("b.State", {13'd0, state_b}, {13'd0, e.st});
        chk("b.Active", {15'd0, active_b}, {15'd0, ea});
        chk("b.Fault", {15'd0, fault_b}, {15'd0, ef});
        chk("b.InstrCount", {14'd0, cnt_b}, e.cnt);
      end
    end
  end

  task automatic step(input int d, input logic r, w, m, wb, h, input logic [2:0] st, input logic [15:0] cnt);
    reset = r; WaitRequest = w; MemOp = m; WbEn = wb; Halt = h;
    @(posedge clk);
    #1;
    q.push_back('{d, st, cnt});
  endtask

  initial begin
    // full MemOp + WbEn instruction
    step(0, 1, 0, 1, 1, 0, 3'd1, 16'd0);
    step(0, 0, 0, 1, 1, 0, 3'd2, 16'd0);
    step(0, 0, 0, 1, 1, 0, 3'd3, 16'd0);
    step(0, 0, 0, 1, 1, 0, 3'd4, 16'd0);
    step(0, 0, 0, 1, 1, 0, 3'd5, 16'd0);
    step(0, 0, 0, 1, 1, 0, 3'd1, 16'd1);
    // plain ALU instruction retires on EXEC->FETCH
    step(0, 0, 0, 0, 0, 0, 3'd2, 16'd1);
    step(0, 0, 1, 0, 0, 0, 3'd3, 16'd1);
    step(0, 0, 1, 0, 0, 0, 3'd1, 16'd2);
    // MEM stall of 3 edges, WbEn dropped during MEM ignored
    step(0, 0, 0, 1, 1, 0, 3'd2, 16'd2);
    step(0, 0, 0, 1, 1, 0, 3'd3, 16'd2);
    step(0, 0, 0, 1, 1, 0, 3'd4, 16'd2);
    step(0, 0, 1, 0, 0, 0, 3'd4, 16'd2);
    step(0, 0, 1, 0, 0, 0, 3'd4, 16'd2);
    step(0, 0, 1, 0, 0, 0, 3'd4, 16'd2);
    step(0, 0, 0, 0, 0, 0, 3'd5, 16'd2);
    step(0, 0, 0, 0, 0, 0, 3'd1, 16'd3);
    // load without writeback: MEM->FETCH retires
    step(0, 0, 0, 1, 0, 0, 3'd2, 16'd3);
    step(0, 0, 0, 1, 0, 0, 3'd3, 16'd3);
    step(0, 0, 0, 1, 0, 0, 3'd4, 16'd3);
    step(0, 0, 0, 1, 1, 0, 3'd1, 16'd4);
    // Halt beats MemOp/WbEn; HALTED absorbing; reset leaves it
    step(0, 0, 0, 0, 0, 0, 3'd2, 16'd4);
    step(0, 0, 0, 0, 0, 0, 3'd3, 16'd4);
    step(0, 0, 0, 1, 1, 1, 3'd0, 16'd5);
    step(0, 0, 1, 0, 0, 0, 3'd0, 16'd5);
    step(0, 0, 0, 0, 0, 0, 3'd0, 16'd5);
    step(0, 0, 1, 1, 1, 0, 3'd0, 16'd5);
    step(0, 1, 0, 0, 0, 0, 3'd1, 16'd0);
    // TIMEOUT=4 instance: 4th stalled FETCH edge faults; FAULT absorbing; reset recovers
    step(1, 1, 0, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd6, 16'd0);
    step(1, 0, 0, 0, 0, 0, 3'd6, 16'd0);
    step(1, 1, 1, 0, 0, 0, 3'd1, 16'd0);
    // 3 stalls then release must not fault (counter cleared by state change)
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 1, 0, 0, 0, 3'd1, 16'd0);
    step(1, 0, 0, 0, 0, 0, 3'd2, 16'd0);
    step(1, 0, 0, 0, 0, 0, 3'd3, 16'd0);
    step(1, 0, 0, 0, 0, 0, 3'd1, 16'd1);
    // CNT_W=2 wrap: 1,2,3,0
    for (int i = 2; i <= 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 3'd2, 16'(i - 1));
      step(1, 0, 0, 0, 0, 0, 3'd3, 16'(i - 1));
      step(1, 0, 0, 0, 0, 0, 3'd1, 16'(i % 4));
    end
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL be parameterised as follows.
- STATE_W, 3, width of State output; minimum 3.
- CNT_W, 16, width of InstrCount.
- TIMEOUT, 255, consecutive stalled cycles before FAULT; 0 disables timeout.
REQ-002 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-003 The block SHALL provide the following ports.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- WaitRequest  input  1  memory busy; stalls memory states.
- MemOp  input  1  current instruction accesses data memory; sampled in EXEC.
- WbEn  input  1  current instruction writes a register; sampled in EXEC.
- Halt  input  1  current instruction halts the CPU; sampled in EXEC.
- State  output  STATE_W  current state encoding.
- Active  output  1  high unless State is HALTED or FAULT.
- Fault  output  1  high while State is FAULT.
- InstrCount  output  CNT_W  completed instructions.

Function
REQ-004 The state encodings SHALL be: HALTED=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WRITEBACK=5, FAULT=6; 7 is unused and SHALL go to FETCH on the next edge.
REQ-005 FETCH SHALL hold while WaitRequest=1 and go to DECODE on the first edge with WaitRequest=0.
REQ-006 DECODE SHALL go to EXEC unconditionally; WaitRequest SHALL be ignored.
REQ-007 EXEC SHALL select its successor with the following priority.
- Halt=1: HALTED.
- Otherwise MemOp=1: MEM.
- Otherwise WbEn=1: WRITEBACK.
- Otherwise: FETCH.
REQ-008 MEM SHALL hold while WaitRequest=1. On the first edge with WaitRequest=0 it SHALL go to WRITEBACK if the WbEn value latched in EXEC is 1, else to FETCH.
REQ-009 WRITEBACK SHALL go to FETCH unconditionally; WaitRequest SHALL be ignored.
REQ-010 HALTED and FAULT SHALL be absorbing; only reset leaves them.
REQ-011 WbEn SHALL be registered on the EXEC edge; later changes to WbEn SHALL NOT affect MEM.
REQ-012 The stall counter (internal) SHALL behave as follows.
- Increments on each edge where the state is FETCH or MEM and WaitRequest=1.
- Clears on any edge where the state changes.
- With TIMEOUT>0: if WaitRequest=1 and the counter equals TIMEOUT-1, the next state SHALL be FAULT. The TIMEOUT-th consecutive stalled edge therefore enters FAULT.
- With TIMEOUT=0: the counter SHALL never cause FAULT.
REQ-013 InstrCount SHALL increment by 1 on each edge that leaves WRITEBACK, leaves MEM to FETCH, or leaves EXEC to FETCH or HALTED. It SHALL wrap from 2^CNT_W-1 to 0.
REQ-014 Active and Fault SHALL be combinational decodes of the registered State; State SHALL be fully registered.

Reset
REQ-015 On a rising edge with reset=1, the block SHALL set State=FETCH, InstrCount=0, stall counter=0 and latched WbEn=0. Active=1 and Fault=0 SHALL follow.
REQ-016 Reset SHALL take priority over every transition, including from HALTED, FAULT or mid-stall, and SHALL have no asynchronous effect.

Verification
REQ-017 The bench SHALL cover the following directed scenarios.
- Reset, then WaitRequest=0, MemOp=1, WbEn=1, Halt=0 -> State 1,2,3,4,5,1 on successive edges; InstrCount=1 after the sixth edge.
- MemOp=0, WbEn=0 -> State 1,2,3,1; InstrCount increments on the EXEC->FETCH edge.
- WaitRequest=1 for 3 cycles in MEM with TIMEOUT=255 -> State stays 4 for 3 edges, then 5 (WbEn latched 1); WbEn dropped during MEM is ignored.
- TIMEOUT=4, WaitRequest held 1 in FETCH -> State=6 and Fault=1 after the 4th stalled edge; the next edge with reset=1 -> State=1, Fault=0, InstrCount=0.
- Halt=1 in EXEC -> State=0, Active=0, InstrCount+1; State stays 0 with WaitRequest toggling; reset -> State=1.
- CNT_W=2, complete 4 instructions -> InstrCount sequence 1,2,3,0.
